pixel_packer: RTL and testbench
===============================

// Module: pixel_packer
// PURPOSE
//  Packs a pull-based stream of 24-bit RGB pixels into dense 32-bit words (4 pixels -> 3 words).
//  Write-side counterpart of the 32->24 pixel unpacker; sits between pixel source and memory/FIFO writer.
//  Both sides are pull/strobe based; mode32 bypasses packing (one zero-extended word per pixel).
// PARAMETERS
//  COUNT_W  16  width of word_count (emitted-word counter, wraps modulo 2**COUNT_W)
// PORTS
//  clk            in   1        clock
//  reset          in   1        synchronous, active-high reset
//  mode32         in   1        1: pass-through {8'h00,in24}; 0: 24->32 packing
//  in24           in   24       input pixel
//  in24_valid     in   1        in24 may be used
//  strobe_in24    out  1        comb.; pixel consumed this cycle, source may advance
//  out32          out  32       packed output word
//  out32_ready    out  1        out32 valid, strobe_out32 may be used
//  strobe_out32   in   1        consumer took out32 this cycle (only legal while out32_ready)
//  word_count     out  COUNT_W  number of words emitted since reset
//  flush          in   1        only with PIXEL_PACKER_FLUSH_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: out32=0, out32_ready=0, state=0, temp=0, word_count=0; reset mid-word discards partial data.
//  - slot_free = !out32_ready || strobe_out32.
//  - Packing state (2 bit), temp (24 bit); big-endian pixel order, first pixel in MSBs:
//    S0: accept if in24_valid (independent of slot_free); temp<=in24; ->S1; no output.
//    S1: accept if in24_valid&&slot_free; out32<={temp[23:0],in24[23:16]}; temp<={8'h0,in24[15:0]}; ->S2.
//    S2: accept if in24_valid&&slot_free; out32<={temp[15:0],in24[23:8]};  temp<={16'h0,in24[7:0]}; ->S3.
//    S3: accept if in24_valid&&slot_free; out32<={temp[7:0],in24};          ->S0.
//  - mode32: accept if in24_valid&&slot_free; out32<={8'h00,in24}; state<=0. mode32 may only
//    toggle while state==0; toggling elsewhere drops the partial word (defined, not an error).
//  - strobe_in24 = accept (combinational, same cycle). Latency: word registered on the accepting
//    clock edge, out32_ready=1 the next cycle.
//  - Word emit: out32_ready<=1, word_count<=word_count+1 (wraps to 0).
//  - strobe_out32 without new word: out32_ready<=0, out32 holds last value.
//  - strobe_out32 and new word in same cycle: out32_ready stays 1, out32 takes new word (no bubble).
//  - Backpressure: S1..S3 stall with strobe_in24=0 while !slot_free; S0 still absorbs one pixel.
//  - in24_valid=0: no state change; out32 unaffected.
// CONFIGURATION
//  PIXEL_PACKER_FLUSH_EN defined: port flush present. flush=1 && state!=0 && slot_free && !mode32:
//    emit zero-padded partial word S1:{temp[23:0],8'h0} S2:{temp[15:0],16'h0} S3:{temp[7:0],24'h0};
//    state<=0, word_count+1. Flush has priority: strobe_in24=0 that cycle. Flush in S0 or with
//    !slot_free: no action (flush must be held until state==0).
//  Not defined: no flush port; partial words are only completed by further pixels.
// TESTING
//  1 mode32=0, pixels 112233,445566,778899,AABBCC, strobe_out32 tied 1 -> words 11223344,
//    55667788,99AABBCC in order; word_count=3; strobe_in24 high 4 cycles back-to-back.
//  2 mode32=1, in24=ABCDEF -> out32=00ABCDEF one cycle after accept; word_count+1 per pixel.
//  3 Backpressure: as 1 but strobe_out32=0 -> after 2nd pixel out32_ready=1, out32=11223344 held;
//    3rd pixel stalls (strobe_in24=0) until strobe_out32 pulse, then 55667788 follows without gap.
//  4 Reset after 2 pixels (state S2), then pixels 010203,040506,070809,0A0B0C
//    -> first word 01020304; no residue of pre-reset pixels; word_count restarted at 0.
//  5 COUNT_W=2: emit 5 words -> word_count sequence 1,2,3,0,1.
//  6 FLUSH_EN: pixels 112233,445566,778899 then flush=1 (in24_valid=1)
//    -> 11223344, 55667788, then 99000000; state=0, no pixel accepted in flush cycle.

Source files
------------

// File: rtl/pixel_packer.sv
// Packs 24-bit RGB pixels into dense 32-bit words (4 pixels -> 3 words), or zero-extends
// one pixel per word in mode32. Optional zero-padded flush: define PIXEL_PACKER_FLUSH_EN.
module pixel_packer #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode32,
  input  logic [23:0]        in24,
  input  logic               in24_valid,
  output logic               strobe_in24,
  output logic [31:0]        out32,
  output logic               out32_ready,
  input  logic               strobe_out32,
`ifdef PIXEL_PACKER_FLUSH_EN
  input  logic               flush,
`endif
  output logic [COUNT_W-1:0] word_count
);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [23:0] temp_r;
  logic [23:0] temp_nxt_s;
  logic        slot_free_s;
  logic        accept_s;
  logic        emit_s;
  logic        flush_go_s;
  logic [31:0] word_s;

  // Next-state, accept and emitted-word selection.
  always_comb begin
    slot_free_s = !out32_ready || strobe_out32;
    accept_s    = 1'b0;
    emit_s      = 1'b0;
    word_s      = out32;
    state_nxt_s = state_r;
    temp_nxt_s  = temp_r;
`ifdef PIXEL_PACKER_FLUSH_EN
    flush_go_s  = flush && (state_r != S0) && slot_free_s && !mode32;
`else
    flush_go_s  = 1'b0;
`endif
    if (flush_go_s) begin
      // Flush wins over a pending pixel; the remaining bytes are zero padding.
      emit_s      = 1'b1;
      state_nxt_s = S0;
      case (state_r)
        S1:      word_s = {temp_r[23:0], 8'h00};
        S2:      word_s = {temp_r[15:0], 16'h0000};
        S3:      word_s = {temp_r[7:0], 24'h000000};
        default: word_s = out32;
      endcase
    end else if (mode32) begin
      if (in24_valid && slot_free_s) begin
        accept_s    = 1'b1;
        emit_s      = 1'b1;
        word_s      = {8'h00, in24};
        state_nxt_s = S0;
      end else begin
        state_nxt_s = state_r;
      end
    end else begin
      case (state_r)
        S0: begin
          // S0 only fills temp, so it may accept even while the output slot is occupied.
          if (in24_valid) begin
            accept_s    = 1'b1;
            temp_nxt_s  = in24;
            state_nxt_s = S1;
          end else begin
            state_nxt_s = S0;
          end
        end
        S1: begin
          if (in24_valid && slot_free_s) begin
            accept_s    = 1'b1;
            emit_s      = 1'b1;
            word_s      = {temp_r[23:0], in24[23:16]};
            temp_nxt_s  = {8'h00, in24[15:0]};
            state_nxt_s = S2;
          end else begin
            state_nxt_s = S1;
          end
        end
        S2: begin
          if (in24_valid && slot_free_s) begin
            accept_s    = 1'b1;
            emit_s      = 1'b1;
            word_s      = {temp_r[15:0], in24[23:8]};
            temp_nxt_s  = {16'h0000, in24[7:0]};
            state_nxt_s = S3;
          end else begin
            state_nxt_s = S2;
          end
        end
        S3: begin
          if (in24_valid && slot_free_s) begin
            accept_s    = 1'b1;
            emit_s      = 1'b1;
            word_s      = {temp_r[7:0], in24};
            state_nxt_s = S0;
          end else begin
            state_nxt_s = S3;
          end
        end
        default: state_nxt_s = S0;
      endcase
    end
  end

  assign strobe_in24 = accept_s;

  // State, partial-pixel store and output word register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S0;
      temp_r      <= 24'h000000;
      out32       <= 32'h00000000;
      out32_ready <= 1'b0;
      word_count  <= {COUNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      temp_r  <= temp_nxt_s;
      if (emit_s) begin
        out32       <= word_s;
        out32_ready <= 1'b1;
        word_count  <= word_count + {{(COUNT_W-1){1'b0}}, 1'b1};
      end else if (strobe_out32) begin
        out32_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_packer.sv
// Self-checking bench for pixel_packer: directed cases plus randomized traffic against
// a byte-stream reference model. Also checks a COUNT_W=2 instance for counter wrap.
module tb_pixel_packer;

`ifdef PIXEL_PACKER_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        mode32;
  logic [23:0] in24;
  logic        in24_valid;
  logic        strobe_out32;
  logic        flush;
  logic        strobe_in24;
  logic [31:0] out32;
  logic        out32_ready;
  logic [15:0] word_count;
  logic        strobe_in24_w2;
  logic [31:0] out32_w2;
  logic        out32_ready_w2;
  logic [1:0]  word_count_w2;

  always #5 clk = ~clk;

  pixel_packer #(.COUNT_W(16)) dut (
    .clk(clk), .reset(reset), .mode32(mode32), .in24(in24), .in24_valid(in24_valid),
    .strobe_in24(strobe_in24), .out32(out32), .out32_ready(out32_ready),
    .strobe_out32(strobe_out32),
`ifdef PIXEL_PACKER_FLUSH_EN
    .flush(flush),
`endif
    .word_count(word_count)
  );

  pixel_packer #(.COUNT_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .mode32(mode32), .in24(in24), .in24_valid(in24_valid),
    .strobe_in24(strobe_in24_w2), .out32(out32_w2), .out32_ready(out32_ready_w2),
    .strobe_out32(strobe_out32),
`ifdef PIXEL_PACKER_FLUSH_EN
    .flush(flush),
`endif
    .word_count(word_count_w2)
  );

  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model: accepted bytes not yet packed, last emitted word, one-deep output slot.
  logic [7:0]  bq[$];
  logic [31:0] exp_word;
  bit          pending;
  int unsigned total;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_emit(input logic [31:0] w);
    exp_word = w;
    pending  = 1'b1;
    total++;
  endtask

  task automatic model_pop_word();
    logic [31:0] w;
    w = {bq[0], bq[1], bq[2], bq[3]};
    repeat (4) void'(bq.pop_front());
    model_emit(w);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    in24_valid   = 1'b0;
    strobe_out32 = 1'b0;
    flush        = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bq.delete();
    pending  = 1'b0;
    exp_word = 32'h00000000;
    total    = 0;
    check_eq("reset_word_count", {16'h0000, word_count}, 32'h00000000);
  endtask

  // One cycle: drive at negedge, check combinational/registered outputs, advance model.
  task automatic step(input bit v, input logic [23:0] px, input bit tk, input bit fl);
    bit take, sf, fgo, acc;
    in24_valid   = v;
    in24         = px;
    strobe_out32 = tk;
    flush        = fl;
    #1;
    take = tk && pending;
    sf   = !pending || tk;
    fgo  = FLUSH_EN && fl && (bq.size() != 0) && sf && !mode32;
    acc  = !fgo && v && (mode32 ? sf : ((bq.size() == 0) || sf));
    check_eq("out32_ready", {31'd0, out32_ready}, {31'd0, pending});
    check_eq("out32", out32, exp_word);
    check_eq("strobe_in24", {31'd0, strobe_in24}, {31'd0, acc});
    if (take) pending = 1'b0;
    if (fgo) begin
      while (bq.size() < 4) bq.push_back(8'h00);
      model_pop_word();
    end else if (acc) begin
      if (mode32) begin
        model_emit({8'h00, px});
      end else begin
        bq.push_back(px[23:16]);
        bq.push_back(px[15:8]);
        bq.push_back(px[7:0]);
        if (bq.size() >= 4) model_pop_word();
      end
    end
    @(negedge clk);
    check_eq("word_count", {16'h0000, word_count}, total % 65536);
    check_eq("word_count_w2", {30'd0, word_count_w2}, total % 4);
  endtask

  initial begin
    reset        = 1'b1;
    mode32       = 1'b0;
    in24         = 24'h000000;
    in24_valid   = 1'b0;
    strobe_out32 = 1'b0;
    flush        = 1'b0;
    @(negedge clk);
    do_reset();
    step(1'b0, 24'h000000, 1'b0, 1'b0);

    // Basic packing with the consumer always taking.
    step(1'b1, 24'h112233, 1'b1, 1'b0);
    step(1'b1, 24'h445566, 1'b1, 1'b0);
    check_eq("t1_word0", out32, 32'h11223344);
    step(1'b1, 24'h778899, 1'b1, 1'b0);
    check_eq("t1_word1", out32, 32'h55667788);
    step(1'b1, 24'hAABBCC, 1'b1, 1'b0);
    check_eq("t1_word2", out32, 32'h99AABBCC);
    check_eq("t1_count", {16'h0000, word_count}, 32'd3);
    step(1'b0, 24'h000000, 1'b1, 1'b0);

    // Pass-through mode.
    do_reset();
    mode32 = 1'b1;
    step(1'b1, 24'hABCDEF, 1'b0, 1'b0);
    check_eq("t2_word", out32, 32'h00ABCDEF);
    step(1'b1, 24'h123456, 1'b1, 1'b0);
    check_eq("t2_word_b", out32, 32'h00123456);
    mode32 = 1'b0;

    // Backpressure: third pixel stalls until the consumer takes the first word.
    do_reset();
    step(1'b1, 24'h112233, 1'b0, 1'b0);
    step(1'b1, 24'h445566, 1'b0, 1'b0);
    step(1'b1, 24'h778899, 1'b0, 1'b0);
    step(1'b1, 24'h778899, 1'b0, 1'b0);
    check_eq("t3_held", out32, 32'h11223344);
    step(1'b1, 24'h778899, 1'b1, 1'b0);
    check_eq("t3_next", out32, 32'h55667788);

    // Reset mid-word leaves no residue.
    do_reset();
    step(1'b1, 24'hDEADBE, 1'b1, 1'b0);
    step(1'b1, 24'hEFCAFE, 1'b1, 1'b0);
    do_reset();
    step(1'b1, 24'h010203, 1'b1, 1'b0);
    step(1'b1, 24'h040506, 1'b1, 1'b0);
    check_eq("t4_first", out32, 32'h01020304);
    step(1'b1, 24'h070809, 1'b1, 1'b0);
    step(1'b1, 24'h0A0B0C, 1'b1, 1'b0);
    check_eq("t4_last", out32, 32'h090A0B0C);

`ifdef PIXEL_PACKER_FLUSH_EN
    do_reset();
    step(1'b1, 24'h112233, 1'b1, 1'b0);
    step(1'b1, 24'h445566, 1'b1, 1'b0);
    step(1'b1, 24'h778899, 1'b1, 1'b0);
    step(1'b1, 24'hAABBCC, 1'b1, 1'b1);
    check_eq("t6_flush_word", out32, 32'h99000000);
    step(1'b0, 24'h000000, 1'b1, 1'b1);
`endif

    // Randomized packing traffic.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 9) < 7, 24'($urandom),
           pending && ($urandom_range(0, 2) != 0), $urandom_range(0, 9) == 0);
    end

    // Randomized pass-through traffic.
    do_reset();
    mode32 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step($urandom_range(0, 9) < 7, 24'($urandom),
           pending && ($urandom_range(0, 1) != 0), $urandom_range(0, 9) == 0);
    end
    mode32 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
